// File: rtl/axi_lite_arb_pkg.sv
// Shared types for the 2x1 AXI-Lite arbiter.
//   arb_state_t  : transaction FSM states
//   grant_t      : one-hot owner vector (bit 0 = instruction port, bit 1 = data port)
//   onehot_port  : maps a port index to its one-hot grant vector
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_XFER = 3'd3,
        ST_WR_RESP = 3'd4
    } arb_state_t;

    localparam int PORT_INS  = 0;
    localparam int PORT_DATA = 1;

    typedef logic [1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;

    function automatic grant_t onehot_port(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_lite_arbiter_2x1_rr.sv
// Two-requester round-robin picker.
//   clk, rst_n : clock and asynchronous active-low reset
//   req_i      : request vector, bit i = port i
//   advance_i  : commit the current pick and move the pointer
//   gnt_o      : one-hot pick for the current request vector (0 when no request)
// The pointer holds the index of the last winner; it resets to port 1 so that
// port 0 takes the first contested arbitration.
module rr_arbiter_2
    import axi_lite_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output grant_t     gnt_o
);

    logic last_q;
    logic last_d;

    // Pick: a lone requester wins, on contention the port after the last winner wins.
    always_comb begin
        gnt_o = GRANT_NONE;
        case (req_i)
            2'b01:   gnt_o = onehot_port(1'b0);
            2'b10:   gnt_o = onehot_port(1'b1);
            2'b11:   gnt_o = onehot_port(~last_q);
            default: gnt_o = GRANT_NONE;
        endcase
    end

    // Next pointer: remember the winner only when the pick is committed.
    always_comb begin
        last_d = last_q;
        if (advance_i && (req_i != 2'b00)) begin
            last_d = gnt_o[PORT_DATA];
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter_2x1.sv
// Shares one AXI-Lite slave between two AXI-Lite masters, one transaction at a time.
//   clk, rst_n : clock and asynchronous active-low reset
//   s0_*       : requester 0 (instruction fetch), slave side
//   s1_*       : requester 1 (data load/store), slave side
//   m_*        : shared downstream slave, master side
//   grant_o    : one-hot owner of the current transaction, 0 when idle
//   busy_o     : high whenever a transaction is in progress
// Grant and state are registered; channels are forwarded combinationally to
// and from the owner, everything else is masked to zero.
module axi_lite_arbiter_2x1
    import axi_lite_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr_i,
    input  logic [2:0]              s0_awprot_i,
    input  logic                    s0_awvalid_i,
    output logic                    s0_awready_o,
    input  logic [DATA_WIDTH-1:0]   s0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb_i,
    input  logic                    s0_wvalid_i,
    output logic                    s0_wready_o,
    output logic [1:0]              s0_bresp_o,
    output logic                    s0_bvalid_o,
    input  logic                    s0_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr_i,
    input  logic [2:0]              s0_arprot_i,
    input  logic                    s0_arvalid_i,
    output logic                    s0_arready_o,
    output logic [DATA_WIDTH-1:0]   s0_rdata_o,
    output logic [1:0]              s0_rresp_o,
    output logic                    s0_rvalid_o,
    input  logic                    s0_rready_i,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr_i,
    input  logic [2:0]              s1_awprot_i,
    input  logic                    s1_awvalid_i,
    output logic                    s1_awready_o,
    input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb_i,
    input  logic                    s1_wvalid_i,
    output logic                    s1_wready_o,
    output logic [1:0]              s1_bresp_o,
    output logic                    s1_bvalid_o,
    input  logic                    s1_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr_i,
    input  logic [2:0]              s1_arprot_i,
    input  logic                    s1_arvalid_i,
    output logic                    s1_arready_o,
    output logic [DATA_WIDTH-1:0]   s1_rdata_o,
    output logic [1:0]              s1_rresp_o,
    output logic                    s1_rvalid_o,
    input  logic                    s1_rready_i,
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic [2:0]              m_awprot_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [1:0]              m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [2:0]              m_arprot_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    output grant_t                  grant_o,
    output logic                    busy_o
);

    localparam int SW = DATA_WIDTH / 8;

    arb_state_t state_q;
    grant_t     grant_q;
    logic       busy_q;
    logic       aw_done_q;
    logic       w_done_q;

    logic [1:0] req_s;
    grant_t     pick_s;
    logic       advance_s;
    logic       win_wr_s;
    logic       g0_s;
    logic       g1_s;
    logic       in_rd_addr_s;
    logic       in_rd_data_s;
    logic       in_wr_xfer_s;
    logic       in_wr_resp_s;
    logic       aw_fin_s;
    logic       w_fin_s;

    // A write on a port takes precedence over a read only at the FSM branch;
    // either valid counts as a request for arbitration.
    assign req_s     = {s1_awvalid_i | s1_arvalid_i, s0_awvalid_i | s0_arvalid_i};
    assign advance_s = (state_q == ST_IDLE) && (req_s != 2'b00);
    assign win_wr_s  = (pick_s[PORT_INS] & s0_awvalid_i) | (pick_s[PORT_DATA] & s1_awvalid_i);

    rr_arbiter_2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_s),
        .advance_i (advance_s),
        .gnt_o     (pick_s)
    );

    assign g0_s         = grant_q[PORT_INS];
    assign g1_s         = grant_q[PORT_DATA];
    assign in_rd_addr_s = (state_q == ST_RD_ADDR);
    assign in_rd_data_s = (state_q == ST_RD_DATA);
    assign in_wr_xfer_s = (state_q == ST_WR_XFER);
    assign in_wr_resp_s = (state_q == ST_WR_RESP);

    // Downstream payloads: AND-OR mux on the one-hot grant, so idle drives zero.
    assign m_awaddr_o = ({ADDR_WIDTH{g0_s}} & s0_awaddr_i) | ({ADDR_WIDTH{g1_s}} & s1_awaddr_i);
    assign m_awprot_o = ({3{g0_s}} & s0_awprot_i) | ({3{g1_s}} & s1_awprot_i);
    assign m_wdata_o  = ({DATA_WIDTH{g0_s}} & s0_wdata_i) | ({DATA_WIDTH{g1_s}} & s1_wdata_i);
    assign m_wstrb_o  = ({SW{g0_s}} & s0_wstrb_i) | ({SW{g1_s}} & s1_wstrb_i);
    assign m_araddr_o = ({ADDR_WIDTH{g0_s}} & s0_araddr_i) | ({ADDR_WIDTH{g1_s}} & s1_araddr_i);
    assign m_arprot_o = ({3{g0_s}} & s0_arprot_i) | ({3{g1_s}} & s1_arprot_i);

    // A completed AW or W channel stops driving valid so the beat is never repeated.
    assign m_awvalid_o = in_wr_xfer_s & ~aw_done_q & ((g0_s & s0_awvalid_i) | (g1_s & s1_awvalid_i));
    assign m_wvalid_o  = in_wr_xfer_s & ~w_done_q  & ((g0_s & s0_wvalid_i)  | (g1_s & s1_wvalid_i));
    assign m_bready_o  = in_wr_resp_s & ((g0_s & s0_bready_i) | (g1_s & s1_bready_i));
    assign m_arvalid_o = in_rd_addr_s & ((g0_s & s0_arvalid_i) | (g1_s & s1_arvalid_i));
    assign m_rready_o  = in_rd_data_s & ((g0_s & s0_rready_i) | (g1_s & s1_rready_i));

    // Upstream: only the owner sees readies and responses.
    assign s0_awready_o = g0_s & in_wr_xfer_s & ~aw_done_q & m_awready_i;
    assign s0_wready_o  = g0_s & in_wr_xfer_s & ~w_done_q  & m_wready_i;
    assign s0_bvalid_o  = g0_s & in_wr_resp_s & m_bvalid_i;
    assign s0_bresp_o   = {2{g0_s & in_wr_resp_s}} & m_bresp_i;
    assign s0_arready_o = g0_s & in_rd_addr_s & m_arready_i;
    assign s0_rvalid_o  = g0_s & in_rd_data_s & m_rvalid_i;
    assign s0_rresp_o   = {2{g0_s & in_rd_data_s}} & m_rresp_i;
    assign s0_rdata_o   = {DATA_WIDTH{g0_s & in_rd_data_s}} & m_rdata_i;

    assign s1_awready_o = g1_s & in_wr_xfer_s & ~aw_done_q & m_awready_i;
    assign s1_wready_o  = g1_s & in_wr_xfer_s & ~w_done_q  & m_wready_i;
    assign s1_bvalid_o  = g1_s & in_wr_resp_s & m_bvalid_i;
    assign s1_bresp_o   = {2{g1_s & in_wr_resp_s}} & m_bresp_i;
    assign s1_arready_o = g1_s & in_rd_addr_s & m_arready_i;
    assign s1_rvalid_o  = g1_s & in_rd_data_s & m_rvalid_i;
    assign s1_rresp_o   = {2{g1_s & in_rd_data_s}} & m_rresp_i;
    assign s1_rdata_o   = {DATA_WIDTH{g1_s & in_rd_data_s}} & m_rdata_i;

    // A write channel counts as finished if it completed earlier or handshakes now.
    assign aw_fin_s = aw_done_q | (m_awvalid_o & m_awready_i);
    assign w_fin_s  = w_done_q  | (m_wvalid_o  & m_wready_i);

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

    // Transaction FSM with registered grant and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= GRANT_NONE;
            busy_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s != 2'b00) begin
                        grant_q <= pick_s;
                        busy_q  <= 1'b1;
                        state_q <= win_wr_s ? ST_WR_XFER : ST_RD_ADDR;
                    end else begin
                        grant_q <= GRANT_NONE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_arvalid_o && m_arready_i) begin
                        state_q <= ST_RD_DATA;
                    end else begin
                        state_q <= ST_RD_ADDR;
                    end
                end
                ST_RD_DATA: begin
                    if (m_rvalid_i && m_rready_o) begin
                        state_q <= ST_IDLE;
                        grant_q <= GRANT_NONE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_RD_DATA;
                    end
                end
                ST_WR_XFER: begin
                    if (aw_fin_s && w_fin_s) begin
                        state_q   <= ST_WR_RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        aw_done_q <= aw_fin_s;
                        w_done_q  <= w_fin_s;
                    end
                end
                ST_WR_RESP: begin
                    if (m_bvalid_i && m_bready_o) begin
                        state_q <= ST_IDLE;
                        grant_q <= GRANT_NONE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_WR_RESP;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    grant_q   <= GRANT_NONE;
                    busy_q    <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// Directed bench for axi_lite_arbiter_2x1: drives and samples on the falling
// edge, plays the downstream slave by hand, and checks routing and sequencing.
module tb_axi_lite_arbiter_2x1;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [AW-1:0] s0_awaddr_i, s1_awaddr_i, s0_araddr_i, s1_araddr_i;
    logic [2:0]    s0_awprot_i, s1_awprot_i, s0_arprot_i, s1_arprot_i;
    logic          s0_awvalid_i, s1_awvalid_i, s0_awready_o, s1_awready_o;
    logic [DW-1:0] s0_wdata_i, s1_wdata_i;
    logic [SW-1:0] s0_wstrb_i, s1_wstrb_i;
    logic          s0_wvalid_i, s1_wvalid_i, s0_wready_o, s1_wready_o;
    logic [1:0]    s0_bresp_o, s1_bresp_o;
    logic          s0_bvalid_o, s1_bvalid_o, s0_bready_i, s1_bready_i;
    logic          s0_arvalid_i, s1_arvalid_i, s0_arready_o, s1_arready_o;
    logic [DW-1:0] s0_rdata_o, s1_rdata_o;
    logic [1:0]    s0_rresp_o, s1_rresp_o;
    logic          s0_rvalid_o, s1_rvalid_o, s0_rready_i, s1_rready_i;

    logic [AW-1:0] m_awaddr_o, m_araddr_o;
    logic [2:0]    m_awprot_o, m_arprot_o;
    logic          m_awvalid_o, m_awready_i;
    logic [DW-1:0] m_wdata_o, m_rdata_i;
    logic [SW-1:0] m_wstrb_o;
    logic          m_wvalid_o, m_wready_i;
    logic [1:0]    m_bresp_i, m_rresp_i;
    logic          m_bvalid_i, m_bready_o;
    logic          m_arvalid_o, m_arready_i;
    logic          m_rvalid_i, m_rready_o;
    logic [1:0]    grant_o;
    logic          busy_o;

    int n_vec = 0;
    int n_err = 0;
    int w_beats = 0;
    int w_start;

    always #5 clk = ~clk;

    // Count downstream W beats to catch a repeated write beat.
    always @(posedge clk) begin
        if (m_wvalid_o && m_wready_i) w_beats <= w_beats + 1;
    end

    axi_lite_arbiter_2x1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_awaddr_i(s0_awaddr_i), .s0_awprot_i(s0_awprot_i), .s0_awvalid_i(s0_awvalid_i), .s0_awready_o(s0_awready_o),
        .s0_wdata_i(s0_wdata_i), .s0_wstrb_i(s0_wstrb_i), .s0_wvalid_i(s0_wvalid_i), .s0_wready_o(s0_wready_o),
        .s0_bresp_o(s0_bresp_o), .s0_bvalid_o(s0_bvalid_o), .s0_bready_i(s0_bready_i),
        .s0_araddr_i(s0_araddr_i), .s0_arprot_i(s0_arprot_i), .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o),
        .s0_rdata_o(s0_rdata_o), .s0_rresp_o(s0_rresp_o), .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i),
        .s1_awaddr_i(s1_awaddr_i), .s1_awprot_i(s1_awprot_i), .s1_awvalid_i(s1_awvalid_i), .s1_awready_o(s1_awready_o),
        .s1_wdata_i(s1_wdata_i), .s1_wstrb_i(s1_wstrb_i), .s1_wvalid_i(s1_wvalid_i), .s1_wready_o(s1_wready_o),
        .s1_bresp_o(s1_bresp_o), .s1_bvalid_o(s1_bvalid_o), .s1_bready_i(s1_bready_i),
        .s1_araddr_i(s1_araddr_i), .s1_arprot_i(s1_arprot_i), .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o),
        .s1_rdata_o(s1_rdata_o), .s1_rresp_o(s1_rresp_o), .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i),
        .m_awaddr_o(m_awaddr_o), .m_awprot_o(m_awprot_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        s0_awaddr_i = '0; s0_awprot_i = '0; s0_awvalid_i = 1'b0; s0_wdata_i = '0; s0_wstrb_i = '0;
        s0_wvalid_i = 1'b0; s0_bready_i = 1'b0; s0_araddr_i = '0; s0_arprot_i = '0; s0_arvalid_i = 1'b0;
        s0_rready_i = 1'b0;
        s1_awaddr_i = '0; s1_awprot_i = '0; s1_awvalid_i = 1'b0; s1_wdata_i = '0; s1_wstrb_i = '0;
        s1_wvalid_i = 1'b0; s1_bready_i = 1'b0; s1_araddr_i = '0; s1_arprot_i = '0; s1_arvalid_i = 1'b0;
        s1_rready_i = 1'b0;
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_bresp_i = 2'b00; m_bvalid_i = 1'b0;
        m_arready_i = 1'b0; m_rdata_i = '0; m_rresp_i = 2'b00; m_rvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One read owned by 'owner', entered at a falling edge while IDLE with the
    // request already raised and m_arready high. Returns at the falling edge
    // after the R handshake.
    task automatic read_phase(input int owner, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [1:0] resp, input bit keep);
        logic [1:0] oh;
        oh = (owner == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        check_vec("rd_grant", grant_o, oh);
        check_vec("rd_busy", busy_o, 1'b1);
        check_vec("rd_m_arvalid", m_arvalid_o, 1'b1);
        check_vec("rd_m_araddr", m_araddr_o, addr);
        check_vec("rd_own_arready", (owner == 0) ? s0_arready_o : s1_arready_o, 1'b1);
        check_vec("rd_other_arready", (owner == 0) ? s1_arready_o : s0_arready_o, 1'b0);
        @(negedge clk);
        if (!keep) begin
            if (owner == 0) s0_arvalid_i = 1'b0;
            else            s1_arvalid_i = 1'b0;
        end
        m_rvalid_i = 1'b1; m_rdata_i = data; m_rresp_i = resp;
        #1;
        check_vec("rd_m_arvalid_off", m_arvalid_o, 1'b0);
        check_vec("rd_own_rvalid", (owner == 0) ? s0_rvalid_o : s1_rvalid_o, 1'b1);
        check_vec("rd_own_rdata", (owner == 0) ? s0_rdata_o : s1_rdata_o, data);
        check_vec("rd_own_rresp", (owner == 0) ? s0_rresp_o : s1_rresp_o, resp);
        check_vec("rd_other_rvalid", (owner == 0) ? s1_rvalid_o : s0_rvalid_o, 1'b0);
        check_vec("rd_other_rdata", (owner == 0) ? s1_rdata_o : s0_rdata_o, 32'h0);
        check_vec("rd_m_rready", m_rready_o, 1'b1);
        @(negedge clk);
        m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = 2'b00;
        check_vec("rd_grant_clear", grant_o, 2'b00);
        check_vec("rd_busy_clear", busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        // Reset: requests and slave readiness present, outputs must stay quiet.
        s0_arvalid_i = 1'b1; s0_araddr_i = 14'h0123; m_arready_i = 1'b1; m_bvalid_i = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("rst_grant", grant_o, 2'b00);
        check_vec("rst_busy", busy_o, 1'b0);
        check_vec("rst_m_arvalid", m_arvalid_o, 1'b0);
        check_vec("rst_m_awvalid", m_awvalid_o, 1'b0);
        check_vec("rst_m_wvalid", m_wvalid_o, 1'b0);
        check_vec("rst_s0_arready", s0_arready_o, 1'b0);
        check_vec("rst_s0_bvalid", s0_bvalid_o, 1'b0);
        idle_inputs();
        rst_n = 1'b1;

        // Single read on s0.
        @(negedge clk);
        s0_araddr_i = 14'h0040; s0_arvalid_i = 1'b1; s0_rready_i = 1'b1; m_arready_i = 1'b1;
        #1;
        check_vec("t1_m_arvalid_early", m_arvalid_o, 1'b0);
        read_phase(0, 14'h0040, 32'hDEADBEEF, 2'b00, 1'b0);

        // Contention from reset: s0, s1, s0, s1.
        do_reset();
        s0_araddr_i = 14'h0010; s1_araddr_i = 14'h0020;
        s0_arvalid_i = 1'b1; s1_arvalid_i = 1'b1; s0_rready_i = 1'b1; s1_rready_i = 1'b1;
        m_arready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            read_phase(k % 2, (k % 2 == 0) ? 14'h0010 : 14'h0020, 32'hA5A50000 + k, 2'b00, 1'b1);
        end
        s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0;

        // Skewed write on s1: W valid three cycles before AW, AW accepted late.
        idle_inputs();
        s1_wdata_i = 32'h12345678; s1_wstrb_i = 4'b0011; s1_wvalid_i = 1'b1; s1_bready_i = 1'b1;
        m_wready_i = 1'b1; m_awready_i = 1'b0;
        w_start = w_beats;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("t3_w_only_no_grant", grant_o, 2'b00);
            check_vec("t3_w_only_no_wvalid", m_wvalid_o, 1'b0);
        end
        s1_awaddr_i = 14'h0100; s1_awvalid_i = 1'b1;
        @(negedge clk);
        check_vec("t3_grant", grant_o, 2'b10);
        check_vec("t3_m_wvalid", m_wvalid_o, 1'b1);
        check_vec("t3_m_wdata", m_wdata_o, 32'h12345678);
        check_vec("t3_m_wstrb", m_wstrb_o, 4'b0011);
        check_vec("t3_s1_wready", s1_wready_o, 1'b1);
        check_vec("t3_s1_awready", s1_awready_o, 1'b0);
        @(negedge clk);
        s1_wvalid_i = 1'b0;
        #1;
        check_vec("t3_w_done_masks", m_wvalid_o, 1'b0);
        check_vec("t3_m_awvalid", m_awvalid_o, 1'b1);
        check_vec("t3_m_awaddr", m_awaddr_o, 14'h0100);
        check_vec("t3_no_bready_yet", m_bready_o, 1'b0);
        m_awready_i = 1'b1;
        #1;
        check_vec("t3_s1_awready_late", s1_awready_o, 1'b1);
        @(negedge clk);
        s1_awvalid_i = 1'b0; m_awready_i = 1'b0; m_bvalid_i = 1'b1; m_bresp_i = 2'b00;
        #1;
        check_vec("t3_m_awvalid_off", m_awvalid_o, 1'b0);
        check_vec("t3_s1_bvalid", s1_bvalid_o, 1'b1);
        check_vec("t3_s1_bresp", s1_bresp_o, 2'b00);
        check_vec("t3_m_bready", m_bready_o, 1'b1);
        check_vec("t3_s0_bvalid", s0_bvalid_o, 1'b0);
        @(negedge clk);
        m_bvalid_i = 1'b0;
        check_vec("t3_grant_clear", grant_o, 2'b00);
        check_vec("t3_single_w_beat", w_beats - w_start, 1);

        // s1 write and read together, with backpressure and error responses.
        idle_inputs();
        s1_awaddr_i = 14'h0200; s1_awvalid_i = 1'b1; s1_wdata_i = 32'hCAFEF00D; s1_wstrb_i = 4'hF;
        s1_wvalid_i = 1'b1; s1_araddr_i = 14'h0300; s1_arvalid_i = 1'b1; s1_rready_i = 1'b1;
        m_awready_i = 1'b1; m_wready_i = 1'b1;
        @(negedge clk);
        check_vec("t4_grant", grant_o, 2'b10);
        check_vec("t4_write_first", m_awvalid_o, 1'b1);
        check_vec("t4_read_held", m_arvalid_o, 1'b0);
        @(negedge clk);
        s1_awvalid_i = 1'b0; s1_wvalid_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
        m_bvalid_i = 1'b1; m_bresp_i = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_vec("t4_bvalid_held", s1_bvalid_o, 1'b1);
            check_vec("t4_bresp_err", s1_bresp_o, 2'b10);
            check_vec("t4_bready_low", m_bready_o, 1'b0);
            @(negedge clk);
        end
        check_vec("t4_wr_busy", busy_o, 1'b1);
        s1_bready_i = 1'b1;
        #1;
        check_vec("t4_bready_fwd", m_bready_o, 1'b1);
        @(negedge clk);
        m_bvalid_i = 1'b0; m_bresp_i = 2'b00; s1_bready_i = 1'b0;
        check_vec("t4_wr_done", grant_o, 2'b00);
        @(negedge clk);
        check_vec("t4_rd_grant", grant_o, 2'b10);
        check_vec("t4_rd_araddr", m_araddr_o, 14'h0300);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_vec("t4_ar_stall", m_arvalid_o, 1'b1);
            check_vec("t4_ar_no_ready", s1_arready_o, 1'b0);
        end
        m_arready_i = 1'b1;
        #1;
        check_vec("t4_ar_ready", s1_arready_o, 1'b1);
        @(negedge clk);
        s1_arvalid_i = 1'b0; m_arready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_vec("t4_r_stall", s1_rvalid_o, 1'b0);
            check_vec("t4_r_owner", grant_o, 2'b10);
            check_vec("t4_r_rready", m_rready_o, 1'b1);
            @(negedge clk);
        end
        m_rvalid_i = 1'b1; m_rdata_i = 32'h0BADCAFE; m_rresp_i = 2'b10;
        #1;
        check_vec("t4_rdata", s1_rdata_o, 32'h0BADCAFE);
        check_vec("t4_rresp_err", s1_rresp_o, 2'b10);
        @(negedge clk);
        m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = 2'b00;
        check_vec("t4_rd_done", busy_o, 1'b0);

        // Reset while s0 is in the data phase of a read.
        idle_inputs();
        s0_araddr_i = 14'h0044; s0_arvalid_i = 1'b1; s0_rready_i = 1'b1; m_arready_i = 1'b1;
        @(negedge clk);
        check_vec("t5_grant", grant_o, 2'b01);
        @(negedge clk);
        s0_arvalid_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h11112222;
        #1;
        check_vec("t5_pre_rvalid", s0_rvalid_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_vec("t5_rst_grant", grant_o, 2'b00);
        check_vec("t5_rst_busy", busy_o, 1'b0);
        check_vec("t5_rst_rvalid", s0_rvalid_o, 1'b0);
        check_vec("t5_rst_rdata", s0_rdata_o, 32'h0);
        check_vec("t5_rst_rready", m_rready_o, 1'b0);
        check_vec("t5_rst_araddr", m_araddr_o, 14'h0);
        @(negedge clk);
        m_rvalid_i = 1'b0; m_rdata_i = '0;
        rst_n = 1'b1;
        // After reset s0 wins the contested arbitration even though it won last.
        s0_araddr_i = 14'h0050; s1_araddr_i = 14'h0060;
        s0_arvalid_i = 1'b1; s1_arvalid_i = 1'b1; s1_rready_i = 1'b1;
        read_phase(0, 14'h0050, 32'h55AA55AA, 2'b00, 1'b0);
        read_phase(1, 14'h0060, 32'h33CC33CC, 2'b10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
